// File: rtl/rf_proto_pkg.sv
// Shared RF link protocol constants and types, used by both the framer and the unpacker.
package rf_proto_pkg;

  localparam int unsigned ASK_LEN  = 4;
  localparam int unsigned CTRL_LEN = 9;
  localparam int unsigned LEN_W    = $clog2(CTRL_LEN + 1);
  // Index of the last byte covered by the ctrl checksum
  localparam int unsigned XOR_LAST = CTRL_LEN - 2;

  localparam logic [7:0] B_IDLE_HDR  = 8'hFA;
  localparam logic [7:0] B_IDLE_TAIL = 8'hFB;
  localparam logic [7:0] B_STOP_TAIL = 8'hFE;
  localparam logic [7:0] B_HDR       = 8'hFF;
  localparam logic [7:0] B_ASK1      = 8'h01;
  localparam logic [7:0] B_ASK2      = 8'h00;
  localparam logic [7:0] B_CTRL_TAIL = 8'h02;

  localparam logic [1:0] ERR_LEN = 2'd0;
  localparam logic [1:0] ERR_HDR = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_OVF = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_RECV = 4'b0010,
    ST_CHK  = 4'b0100,
    ST_DROP = 4'b1000
  } rf_state_t;

  typedef struct packed {
    logic [15:0] freq;
    logic [31:0] agin;
  } rf_ctrl_t;

  typedef logic [CTRL_LEN-1:0][7:0] rf_bytes_t;

endpackage

// File: rtl/rf_frame_buf.sv
// Frame capture buffer: stores incoming bytes, tracks length and the running checksum XOR.
module rf_frame_buf
  import rf_proto_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             push,
  input  logic [7:0]       data,
  output rf_bytes_t        bytes,
  output logic [LEN_W-1:0] len,
  output logic [7:0]       xsum,
  output logic             full_c
);

  assign full_c = (len == LEN_W'(CTRL_LEN));

  // start opens a new frame with byte0; push appends while room remains
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes <= '0;
      len   <= '0;
      xsum  <= '0;
    end else if (start) begin
      bytes[0] <= data;
      len      <= LEN_W'(1);
      xsum     <= data;
    end else if (push && !full_c) begin
      bytes[len] <= data;
      len        <= len + LEN_W'(1);
      if (len <= LEN_W'(XOR_LAST)) begin
        xsum <= xsum ^ data;
      end
    end
  end

endmodule

// File: rtl/rf_unpack.sv
// RF link receiver: delimits frames by vld bursts, decodes ask/ctrl frames, reports errors and counts.
module rf_unpack
  import rf_proto_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         i_rf_data,
  input  logic               i_rf_vld,
  output logic               o_ask_vld,
  output logic               o_ask_type,
  output logic               o_ctrl_vld,
  output logic [15:0]        o_rf_freq,
  output logic [31:0]        o_rfc_agin,
  output logic               o_err,
  output logic [1:0]         o_err_code,
  output logic [2*CNT_W-1:0] o_rx_num,
  output logic [CNT_W-1:0]   o_err_num
);

  rf_state_t        state_q, state_d;
  logic             buf_start, buf_push;
  rf_bytes_t        bytes;
  logic [LEN_W-1:0] len;
  logic [7:0]       xsum;
  logic             full_c;

  logic             ask_vld_d, ask_type_d, ctrl_vld_d, err_d;
  logic [1:0]       err_code_d;
  rf_ctrl_t         fields_q, fields_d;
  logic [CNT_W-1:0] ask_cnt_q, ctrl_cnt_q, err_cnt_q;

  rf_frame_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .start  (buf_start),
    .push   (buf_push),
    .data   (i_rf_data),
    .bytes  (bytes),
    .len    (len),
    .xsum   (xsum),
    .full_c (full_c)
  );

  // Frame classification from the captured bytes
  logic is_ask_len, is_ctrl_len, idle_match, stop_match, ctrl_hdr_ok, chk_ok;
  assign is_ask_len  = (len == LEN_W'(ASK_LEN));
  assign is_ctrl_len = (len == LEN_W'(CTRL_LEN));
  assign idle_match  = ({bytes[0], bytes[1], bytes[2], bytes[3]} ==
                        {B_IDLE_HDR, B_ASK1, B_ASK2, B_IDLE_TAIL});
  assign stop_match  = ({bytes[0], bytes[1], bytes[2], bytes[3]} ==
                        {B_HDR, B_ASK1, B_ASK2, B_STOP_TAIL});
  assign ctrl_hdr_ok = (bytes[0] == B_HDR) && (bytes[7] == B_CTRL_TAIL);
  assign chk_ok      = (bytes[8] == xsum);

  always_comb begin
    state_d    = state_q;
    buf_start  = 1'b0;
    buf_push   = 1'b0;
    ask_vld_d  = 1'b0;
    ctrl_vld_d = 1'b0;
    err_d      = 1'b0;
    ask_type_d = o_ask_type;
    err_code_d = o_err_code;
    fields_d   = fields_q;
    case (state_q)
      ST_IDLE: begin
        if (i_rf_vld) begin
          buf_start = 1'b1;
          state_d   = ST_RECV;
        end
      end
      ST_RECV: begin
        if (!i_rf_vld) begin
          state_d = ST_CHK;
        end else if (full_c) begin
          state_d = ST_DROP;
        end else begin
          buf_push = 1'b1;
        end
      end
      ST_CHK: begin
        if (is_ask_len) begin
          if (idle_match) begin
            ask_vld_d  = 1'b1;
            ask_type_d = 1'b0;
          end else if (stop_match) begin
            ask_vld_d  = 1'b1;
            ask_type_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_HDR;
          end
        end else if (is_ctrl_len) begin
          if (!ctrl_hdr_ok) begin
            err_d      = 1'b1;
            err_code_d = ERR_HDR;
          end else if (!chk_ok) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end else begin
            ctrl_vld_d    = 1'b1;
            fields_d.freq = {bytes[1], bytes[2]};
            fields_d.agin = {bytes[3], bytes[4], bytes[5], bytes[6]};
          end
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_LEN;
        end
        // A byte arriving during the check cycle opens the next frame
        if (i_rf_vld) begin
          buf_start = 1'b1;
          state_d   = ST_RECV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!i_rf_vld) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVF;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      o_ask_vld  <= 1'b0;
      o_ask_type <= 1'b0;
      o_ctrl_vld <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= ERR_LEN;
      fields_q   <= '0;
      ask_cnt_q  <= '0;
      ctrl_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      o_ask_vld  <= ask_vld_d;
      o_ask_type <= ask_type_d;
      o_ctrl_vld <= ctrl_vld_d;
      o_err      <= err_d;
      o_err_code <= err_code_d;
      fields_q   <= fields_d;
      if (ask_vld_d)  ask_cnt_q  <= ask_cnt_q + CNT_W'(1);
      if (ctrl_vld_d) ctrl_cnt_q <= ctrl_cnt_q + CNT_W'(1);
      if (err_d)      err_cnt_q  <= err_cnt_q + CNT_W'(1);
    end
  end

  assign o_rf_freq  = fields_q.freq;
  assign o_rfc_agin = fields_q.agin;
  assign o_rx_num   = {ask_cnt_q, ctrl_cnt_q};
  assign o_err_num  = err_cnt_q;

endmodule

// File: tb/tb_rf_unpack.sv
// Scoreboard bench for rf_unpack: directed frames queue expected pulses, a monitor checks them.
module tb_rf_unpack;

  localparam int unsigned CW = 10;
  localparam int K_ASK  = 0;
  localparam int K_CTRL = 1;
  localparam int K_ERR  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rf_data = 8'h00;
  logic          rf_vld = 1'b0;
  logic          o_ask_vld, o_ask_type, o_ctrl_vld, o_err;
  logic [15:0]   o_rf_freq;
  logic [31:0]   o_rfc_agin;
  logic [1:0]    o_err_code;
  logic [2*CW-1:0] o_rx_num;
  logic [CW-1:0] o_err_num;

  rf_unpack #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rf_data  (rf_data),
    .i_rf_vld   (rf_vld),
    .o_ask_vld  (o_ask_vld),
    .o_ask_type (o_ask_type),
    .o_ctrl_vld (o_ctrl_vld),
    .o_rf_freq  (o_rf_freq),
    .o_rfc_agin (o_rfc_agin),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_rx_num   (o_rx_num),
    .o_err_num  (o_err_num)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    logic          typ;
    logic [1:0]    code;
    logic [15:0]   freq;
    logic [31:0]   agin;
    logic [CW-1:0] ask_n;
    logic [CW-1:0] ctrl_n;
    logic [CW-1:0] err_n;
    int            at;
  } exp_t;

  exp_t sb[$];

  logic [CW-1:0] m_ask = '0, m_ctrl = '0, m_err = '0;
  logic          m_type = 1'b0;
  logic [1:0]    m_code = 2'd0;
  logic [15:0]   m_freq = '0;
  logic [31:0]   m_agin = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_exp(input int kind, input logic typ, input logic [1:0] code,
                                   input logic [15:0] freq, input logic [31:0] agin, input int at);
    exp_t e;
    if (kind == K_ASK) begin
      m_ask  = m_ask + CW'(1);
      m_type = typ;
    end else if (kind == K_CTRL) begin
      m_ctrl = m_ctrl + CW'(1);
      m_freq = freq;
      m_agin = agin;
    end else begin
      m_err  = m_err + CW'(1);
      m_code = code;
    end
    e.kind = kind;   e.typ = m_type;   e.code = m_code;
    e.freq = m_freq; e.agin = m_agin;
    e.ask_n = m_ask; e.ctrl_n = m_ctrl; e.err_n = m_err;
    e.at = at;
    sb.push_back(e);
  endfunction

  // Drive n bytes (first byte in the most significant position of v), then gap idle cycles
  task automatic send(input logic [95:0] v, input int n, input int gap, input int kind,
                      input logic typ, input logic [1:0] code,
                      input logic [15:0] freq, input logic [31:0] agin);
    int last;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rf_vld  = 1'b1;
      rf_data = v[8*(n-1-i) +: 8];
    end
    last = cyc;
    push_exp(kind, typ, code, freq, agin, last + ((kind == K_ERR && code == 2'd3) ? 2 : 3));
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      rf_vld  = 1'b0;
      rf_data = 8'h00;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected pulses never seen", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ask_vld"},  64'(o_ask_vld),  64'd0);
    chk({tag, "_ask_type"}, 64'(o_ask_type), 64'd0);
    chk({tag, "_ctrl_vld"}, 64'(o_ctrl_vld), 64'd0);
    chk({tag, "_freq"},     64'(o_rf_freq),  64'd0);
    chk({tag, "_agin"},     64'(o_rfc_agin), 64'd0);
    chk({tag, "_err"},      64'(o_err),      64'd0);
    chk({tag, "_err_code"}, 64'(o_err_code), 64'd0);
    chk({tag, "_rx_num"},   64'(o_rx_num),   64'd0);
    chk({tag, "_err_num"},  64'(o_err_num),  64'd0);
  endtask

  int   mon_kind;
  exp_t mon_e;

  // Monitor: every output pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (o_ask_vld || o_ctrl_vld || o_err)) begin
      chk("pulse_onehot", 64'(32'(o_ask_vld) + 32'(o_ctrl_vld) + 32'(o_err)), 64'd1);
      mon_kind = o_ctrl_vld ? K_CTRL : (o_err ? K_ERR : K_ASK);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", mon_kind, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("kind",     64'(mon_kind),   64'(mon_e.kind));
        chk("latency",  64'(cyc),        64'(mon_e.at));
        chk("ask_type", 64'(o_ask_type), 64'(mon_e.typ));
        chk("err_code", 64'(o_err_code), 64'(mon_e.code));
        chk("rf_freq",  64'(o_rf_freq),  64'(mon_e.freq));
        chk("rfc_agin", 64'(o_rfc_agin), 64'(mon_e.agin));
        chk("rx_num",   64'(o_rx_num),   64'({mon_e.ask_n, mon_e.ctrl_n}));
        chk("err_num",  64'(o_err_num),  64'(mon_e.err_n));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [95:0] CTRL_OK  = 96'hFF1234DEADBEEF02F9;
  localparam logic [95:0] CTRL_BAD = 96'hFF1234DEADBEEF02F8;

  initial begin
    int nwrap;
    repeat (3) @(posedge clk);
    #1;
    check_zero("init");
    rst = 1'b0;

    // Idle ask, counter layout
    send(96'hFA0100FB, 4, 2, K_ASK, 1'b0, 2'd0, 16'h0, 32'h0);
    drain();

    // Good ctrl, then checksum failure that must leave fields alone
    send(CTRL_OK, 9, 2, K_CTRL, 1'b0, 2'd0, 16'h1234, 32'hDEADBEEF);
    send(CTRL_BAD, 9, 2, K_ERR, 1'b0, 2'd2, 16'h0, 32'h0);
    drain();

    // Stop ask followed by ctrl after a single idle cycle
    send(96'hFF0100FE, 4, 1, K_ASK, 1'b1, 2'd0, 16'h0, 32'h0);
    send(CTRL_OK, 9, 2, K_CTRL, 1'b0, 2'd0, 16'h1234, 32'hDEADBEEF);
    drain();

    // Overflow, length, header errors
    send(96'hFF1234DEADBEEF02F900, 10, 2, K_ERR, 1'b0, 2'd3, 16'h0, 32'h0);
    send(96'hFA0100, 3, 2, K_ERR, 1'b0, 2'd0, 16'h0, 32'h0);
    send(96'hFA0100FE, 4, 2, K_ERR, 1'b0, 2'd1, 16'h0, 32'h0);
    send(96'hFF1234DEADBEEF03F8, 9, 2, K_ERR, 1'b0, 2'd1, 16'h0, 32'h0);
    send(96'h55, 1, 2, K_ERR, 1'b0, 2'd0, 16'h0, 32'h0);
    send(96'hFF1234DEADBEEF02F9AB, 10, 1, K_ERR, 1'b0, 2'd3, 16'h0, 32'h0);
    drain();

    // Reset in the middle of a ctrl frame
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rf_vld  = 1'b1;
      rf_data = CTRL_OK[8*(8-i) +: 8];
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rf_data = 8'hBE;
    @(posedge clk); #1;
    rf_vld = 1'b0;
    @(posedge clk); #1;
    check_zero("rst");
    rst = 1'b0;
    m_ask = '0; m_ctrl = '0; m_err = '0;
    m_type = 1'b0; m_code = 2'd0; m_freq = '0; m_agin = '0;
    send(CTRL_OK, 9, 2, K_CTRL, 1'b0, 2'd0, 16'h1234, 32'hDEADBEEF);
    drain();

    // Ask counter wrap, ctrl counter untouched
    nwrap = (1 << CW) - int'(m_ask);
    for (int i = 0; i < nwrap; i++) begin
      send(96'hFA0100FB, 4, 1, K_ASK, 1'b0, 2'd0, 16'h0, 32'h0);
    end
    @(posedge clk); #1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_ask_cnt",  64'(o_rx_num[2*CW-1:CW]), 64'd0);
    chk("wrap_ctrl_cnt", 64'(o_rx_num[CW-1:0]),    64'd1);
    chk("sb_empty",      64'(sb.size()),           64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
